// File: rtl/bus_step_ctl_if.sv
// CPU bus / command side of the PHI-domain step controller.
// Port names follow the CPU pin names so the wiring at the top level reads naturally.
interface bus_step_ctl_if;
  logic        MREQ;
  logic        IORQ;
  logic [19:0] A;
  logic [7:0]  cmd;
  logic        cmd_stb;
  logic        capture_done;
  logic        wait_oe;
  logic        holding;
  logic        bp_hit;
  logic [7:0]  status;

  modport slave  (input  MREQ, IORQ, A, cmd, cmd_stb, capture_done,
                  output wait_oe, holding, bp_hit, status);
  modport master (output MREQ, IORQ, A, cmd, cmd_stb, capture_done,
                  input  wait_oe, holding, bp_hit, status);
endinterface

// File: rtl/bus_step_ctl.sv
// Per-bus-cycle /WAIT sequencer: free-run with breakpoint, halt/single-step, and trace.
// All state is on posedge PHI; RESET is asynchronous active-low.
module bus_step_ctl #(
  parameter logic [1:0]  RESET_MODE = 2'd0,
  parameter logic [19:0] BP_RESET   = 20'h00000
) (
  input  logic           PHI,
  input  logic           RESET,
  bus_step_ctl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [1:0] M_RUN = 2'd0, M_HALT = 2'd1, M_TRACE = 2'd2;

  state_t      state, nxt;
  logic [1:0]  mode;
  logic        bp_en, hit, idle_q, hold_q;
  logic [19:0] bp_addr;
  logic [11:0] shadow;
  logic [1:0]  cnt;

  logic idle, start, op_stb, is_run, is_step, bp_match, hold_cond, rel_ev, bp_take;

  assign idle      = bus.MREQ & bus.IORQ;
  assign start     = idle_q & ~idle;
  assign op_stb    = bus.cmd_stb && (cnt == 2'd0);
  assign is_run    = op_stb && (bus.cmd == 8'h00);
  assign is_step   = op_stb && (bus.cmd == 8'h03);
  assign bp_match  = (mode == M_RUN) && bp_en && !bus.MREQ && (bus.A == bp_addr);
  assign hold_cond = (mode == M_HALT) || (mode == M_TRACE) || bp_match;
  // mode==RUN while held only happens when RUN arrived on the same edge as the
  // cycle start; that cycle is held once and then let go on the following edge.
  assign rel_ev    = is_run || is_step || (bus.capture_done && mode == M_TRACE) ||
                     (mode == M_RUN);
  assign bp_take   = (state == IDLE) && start && bp_match;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = hold_cond ? HOLD : ACTIVE;
      ACTIVE:  if (idle) nxt = IDLE;
      HOLD:    if (idle) nxt = IDLE;
               else if (rel_ev) nxt = ACTIVE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge PHI or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      mode    <= RESET_MODE;
      bp_en   <= 1'b0;
      bp_addr <= BP_RESET;
      shadow  <= '0;
      cnt     <= 2'd0;
      hit     <= 1'b0;
      idle_q  <= 1'b1;
      hold_q  <= 1'b0;
    end else begin
      idle_q <= idle;
      state  <= nxt;
      hold_q <= (nxt == HOLD);
      if (op_stb) begin
        case (bus.cmd)
          8'h00:   mode  <= M_RUN;
          8'h01:   mode  <= M_HALT;
          8'h02:   mode  <= M_TRACE;
          8'h03:   mode  <= M_HALT;
          8'h04:   bp_en <= 1'b0;
          8'h05:   bp_en <= 1'b1;
          8'h06:   hit   <= 1'b0;
          8'h10:   cnt   <= 2'd3;
          default: ;
        endcase
      end else if (bus.cmd_stb) begin
        // Address bytes land in the shadow; bp_addr changes only on the last one.
        cnt <= cnt - 2'd1;
        case (cnt)
          2'd3:    shadow[11:8] <= bus.cmd[3:0];
          2'd2:    shadow[7:0]  <= bus.cmd;
          default: bp_addr      <= {shadow, bus.cmd};
        endcase
      end
      if (bp_take) begin
        mode <= M_HALT;
        hit  <= 1'b1;
      end
    end
  end

  assign bus.wait_oe = hold_q;
  assign bus.holding = hold_q;
  assign bus.bp_hit  = hit;
  assign bus.status  = {hit, bp_en, mode, state, (cnt != 2'd0), hold_q};
endmodule

// File: tb/tb_bus_step_ctl.sv
// Scoreboard bench for bus_step_ctl: stimulus pushes model predictions, a negedge monitor compares.
module tb_bus_step_ctl;
  logic PHI = 1'b0;
  logic RESET = 1'b0;
  bus_step_ctl_if bus ();

  bus_step_ctl #(.RESET_MODE(2'd0), .BP_RESET(20'h00000)) dut (.PHI(PHI), .RESET(RESET), .bus(bus));

  always #5 PHI = ~PHI;

  typedef struct packed { logic w; logic h; logic b; logic [7:0] s; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  // Reference model: bus phase 0 = between cycles, 1 = running, 2 = held.
  int          m_mode, m_need, m_phase;
  bit          m_bpen, m_hit, m_idleq, m_runrel;
  logic [19:0] m_bp;
  logic [7:0]  m_bytes[$];
  logic        b_mreq = 1'b1, b_iorq = 1'b1;
  logic [19:0] b_a = '0;

  function automatic void model_reset();
    m_mode = 0; m_need = 0; m_phase = 0; m_bpen = 0; m_hit = 0;
    m_idleq = 1; m_runrel = 0; m_bp = 20'h00000; m_bytes.delete();
  endfunction

  function automatic void model_step(bit mreq, bit iorq, logic [19:0] a, logic [7:0] c, bit stb, bit cap);
    bit idle = mreq & iorq;
    bit start = m_idleq && !idle;
    int om = m_mode;
    int op = (stb && m_need == 0) ? int'(c) : -1;
    bit bphold = start && m_phase == 0 && om == 0 && m_bpen && !mreq && a == m_bp;
    case (m_phase)
      0: if (start) begin
           if (om != 0 || bphold) begin m_phase = 2; m_runrel = (op == 0) && !bphold; end
           else m_phase = 1;
         end
      1: if (idle) m_phase = 0;
      default:
         if (idle) begin m_phase = 0; m_runrel = 0; end
         else if (op == 0 || op == 3 || (cap && om == 2) || m_runrel) begin
           m_phase = 1; m_runrel = 0;
         end
    endcase
    if (stb && m_need > 0) begin
      m_bytes.push_back(c);
      m_need--;
      if (m_need == 0) begin
        m_bp = {m_bytes[0][3:0], m_bytes[1], m_bytes[2]};
        m_bytes.delete();
      end
    end else if (stb) begin
      case (c)
        8'h00: m_mode = 0;
        8'h01, 8'h03: m_mode = 1;
        8'h02: m_mode = 2;
        8'h04: m_bpen = 0;
        8'h05: m_bpen = 1;
        8'h06: m_hit = 0;
        8'h10: begin m_need = 3; m_bytes.delete(); end
        default: ;
      endcase
    end
    if (bphold) begin m_mode = 1; m_hit = 1; end
    m_idleq = idle;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.w = (m_phase == 2);
    e.h = (m_phase == 2);
    e.b = m_hit;
    e.s = {m_hit, m_bpen, 2'(m_mode), 2'(m_phase), m_need != 0, m_phase == 2};
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge PHI);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wait_oe", {7'd0, bus.wait_oe}, {7'd0, e.w});
        chk("holding", {7'd0, bus.holding}, {7'd0, e.h});
        chk("bp_hit",  {7'd0, bus.bp_hit},  {7'd0, e.b});
        chk("status",  bus.status, e.s);
      end
    end
  end

  task automatic tick(input logic [7:0] c, input bit stb, input bit cap);
    bus.MREQ = b_mreq; bus.IORQ = b_iorq; bus.A = b_a;
    bus.cmd = c; bus.cmd_stb = stb; bus.capture_done = cap;
    @(posedge PHI);
    model_step(b_mreq, b_iorq, b_a, c, stb, cap);
    sb.push_back(model_out());
    #1;
    bus.cmd_stb = 1'b0; bus.capture_done = 1'b0;
  endtask

  task automatic go_idle(input int n);
    b_mreq = 1; b_iorq = 1;
    repeat (n) tick(8'h00, 0, 0);
  endtask

  task automatic send(input logic [7:0] c);
    b_mreq = 1; b_iorq = 1;
    tick(c, 1, 0);
  endtask

  task automatic bus_cycle(input bit io, input logic [19:0] a, input int n);
    b_mreq = io; b_iorq = !io; b_a = a;
    repeat (n) tick(8'h00, 0, 0);
  endtask

  task automatic async_reset();
    @(negedge PHI);
    #1 RESET = 1'b0;
    #1;
    chk("rst_wait_oe", {7'd0, bus.wait_oe}, 8'd0);
    chk("rst_status", bus.status, 8'h00);
    model_reset();
    @(negedge PHI);
    RESET = 1'b1;
  endtask

  logic [7:0] cmd_tbl [9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h10, 8'h7F};

  initial begin : stim
    bus.MREQ = 1; bus.IORQ = 1; bus.A = '0; bus.cmd = '0; bus.cmd_stb = 0; bus.capture_done = 0;
    model_reset();
    #2;
    chk("reset_wait_oe", {7'd0, bus.wait_oe}, 8'd0);
    chk("reset_status", bus.status, 8'h00);
    #10 RESET = 1'b1;

    // free run
    for (int i = 0; i < 10; i++) begin go_idle(1); bus_cycle(0, 20'(i * 17), 2); end
    // trace: hold until capture, next cycle holds again
    go_idle(1); send(8'h02); go_idle(1);
    bus_cycle(0, 20'h00100, 21);
    tick(8'h00, 0, 1);
    bus_cycle(0, 20'h00100, 1);
    go_idle(1); bus_cycle(0, 20'h00101, 3); tick(8'h00, 0, 1); go_idle(1);
    // breakpoint load and hit
    send(8'h00); send(8'h10); send(8'h0A); send(8'h12); send(8'h34); send(8'h05);
    go_idle(1); bus_cycle(0, 20'hA1235, 3);
    go_idle(1); bus_cycle(1, 20'hA1234, 3);
    go_idle(1); bus_cycle(0, 20'hA1234, 3);
    // halt/step; capture ignored outside trace
    tick(8'h03, 1, 0); bus_cycle(0, 20'hA1234, 1);
    go_idle(1); bus_cycle(0, 20'h00200, 2);
    tick(8'h00, 0, 1); tick(8'h00, 0, 0); tick(8'h03, 1, 0); go_idle(1);
    // capture + step together in trace hold
    send(8'h02); go_idle(1); bus_cycle(0, 20'h00300, 2);
    tick(8'h03, 1, 1); bus_cycle(0, 20'h00300, 1); go_idle(1);
    // RUN on the cycle-start edge while halted
    b_mreq = 0; b_a = 20'h00400; tick(8'h00, 1, 0); tick(8'h00, 0, 0); tick(8'h00, 0, 0);
    go_idle(1);
    // reset while held mid-load
    send(8'h02); go_idle(1); bus_cycle(0, 20'h00500, 2);
    tick(8'h10, 1, 0); tick(8'h0A, 1, 0);
    async_reset();
    send(8'h05); go_idle(1); bus_cycle(0, 20'h00000, 2);
    tick(8'h00, 1, 0); go_idle(1); send(8'h06); go_idle(1);

    // randomized bus cycles and commands
    for (int n = 0; n < 150; n++) begin
      int gap, k;
      logic [19:0] a;
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        b_mreq = 1; b_iorq = 1;
        tick(cmd_tbl[$urandom_range(0, 8)], ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      end
      case ($urandom_range(0, 2))
        0: a = m_bp;
        1: a = m_bp + 20'd1;
        default: a = 20'($urandom);
      endcase
      b_mreq = ($urandom_range(0, 4) == 0); b_iorq = !b_mreq; b_a = a;
      k = 0;
      while (k < 2 || (m_phase == 2 && k < 20)) begin
        tick(cmd_tbl[$urandom_range(0, 8)], ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        k++;
      end
      if (m_phase == 2 && m_need == 0) tick(8'h00, 1, 0);
    end
    go_idle(2);

    #20;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
